// File: rtl/seq_normalizer.sv
// seq_normalizer
//   Multi-cycle left-normalizer. It accepts one word, finds its leading-zero
//   count by binary search (one power-of-two stage per clock) and returns the
//   word shifted so that its leading one sits at the MSB.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept a word (IDLE only)
//   in_data    word to normalize, sampled on the accept edge only
//   out_valid  result is valid (DONE only)
//   out_ready  downstream accepts the result
//   out_data   in_data << out_shift, truncated to WIDTH
//   out_shift  leading-zero count (all ones for a zero input)
//   out_zero   input word was zero
module seq_normalizer #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_BITS = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SHIFT_BITS-1:0] out_shift,
    output logic                  out_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        work;
    logic [SHIFT_BITS-1:0]   acc;
    logic [SHIFT_BITS-1:0]   k;
    logic                    zero_q;

    logic [SHIFT_BITS:0]     step;
    logic [WIDTH-1:0]        top_mask;
    logic                    top_zero;
    logic [WIDTH-1:0]        shifted;
    logic                    accept;
    logic                    out_fire;

    // Stage datapath: test the top 2^k bits and conditionally shift by 2^k.
    always_comb begin
        step     = (SHIFT_BITS+1)'(1) << k;
        top_mask = ~({WIDTH{1'b1}} >> step);
        top_zero = ((work & top_mask) == '0);
        shifted  = top_zero ? (work << step) : work;
    end

    // Handshake strobes are decoded from the state register only, so neither
    // ready nor valid ever depends combinationally on the other side.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (k == '0) state_nxt = DONE;
            DONE:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work   <= '0;
            acc    <= '0;
            k      <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work   <= in_data;
                        acc    <= '0;
                        k      <= SHIFT_BITS'(SHIFT_BITS-1);
                        zero_q <= 1'b0;
                    end
                end
                RUN: begin
                    work <= shifted;
                    if (top_zero) acc <= acc | (SHIFT_BITS'(1) << k);
                    k <= k - 1'b1;
                    // After the last stage a nonzero word has its MSB set, so
                    // an all-zero register can only come from a zero input.
                    if (k == '0) zero_q <= (shifted == '0);
                end
                default: ;
            endcase
        end
    end

    assign out_data  = work;
    assign out_shift = acc;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
module tb_seq_normalizer;
    localparam int WIDTH = 32;
    localparam int SB    = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [SB-1:0]    out_shift;
    logic             out_zero;

    seq_normalizer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_shift(out_shift), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: linear scan for the leading one.
    function automatic void ref_norm(input logic [31:0] d, output logic [31:0] nd,
                                     output logic [4:0] sh, output logic z);
        z  = (d == 0);
        sh = 0;
        nd = d;
        if (d == 0) begin
            sh = 5'd31;
        end else begin
            while (!nd[31]) begin
                nd = nd << 1;
                sh = sh + 1'b1;
            end
        end
    endfunction

    // Full transaction with out_ready high; reports result and accept-to-valid latency.
    task automatic run_word(input logic [31:0] d, output logic [31:0] od,
                            output logic [4:0] os, output logic oz, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        od = out_data; os = out_shift; oz = out_zero;
        chk("in_ready_in_done", in_ready, 0);
        @(posedge clk); #1;
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [4:0]  sh;
        logic        z;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] q[$];

    initial begin
        logic [31:0] od, rd, d;
        logic [4:0]  os, rs;
        logic        oz, rz;
        int          lat, n, got, cyc, s;

        vecs[0] = '{32'h0001_0000, 32'h8000_0000, 5'd15, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0};
        vecs[2] = '{32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1};
        vecs[4] = '{32'h0000_F000, 32'hF000_0000, 5'd16, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h91A2_B3C0, 5'd3,  1'b0};
        vecs[6] = '{32'h4000_0000, 32'h8000_0000, 5'd1,  1'b0};
        vecs[7] = '{32'h0000_0003, 32'hC000_0000, 5'd30, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0};
        vecs[9] = '{32'h0000_8001, 32'h8001_0000, 5'd16, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_shift", out_shift, 0);
        chk("rst_out_zero", out_zero, 0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i].din, od, os, oz, lat);
            chk($sformatf("vec%0d_data", i), od, vecs[i].dout);
            chk($sformatf("vec%0d_shift", i), os, vecs[i].sh);
            chk($sformatf("vec%0d_zero", i), oz, vecs[i].z);
            chk($sformatf("vec%0d_latency", i), lat, SB);
        end

        // Backpressure: hold out_ready low with in_valid high and data churning.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 32'h0040_0000;
        out_ready = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (!out_valid && n < 50) begin
            in_data = $urandom;
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_data = $urandom;
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_data", out_data, 32'h8000_0000);
            chk("bp_out_shift", out_shift, 9);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_out_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_no_second_accept", in_ready, 1);

        // Reset during RUN at stage k=2 (third stage edge).
        in_valid  = 1'b1;
        in_data   = 32'h0000_0100;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_shift", out_shift, 0);
        chk("mid_rst_out_zero", out_zero, 0);
        out_ready = 1'b0;
        run_word(32'h0000_F000, od, os, oz, lat);
        chk("post_rst_data", od, 32'hF000_0000);
        chk("post_rst_shift", os, 16);
        chk("post_rst_zero", oz, 0);

        // Random sweep with random out_ready, scoreboarded in order.
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 32);
            d = $urandom | 32'h8000_0000;
            in_data = (s == 32) ? 32'h0 : (d >> s);
            out_ready = $urandom_range(0, 1);
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(in_data);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sweep_spurious_out", 1, 0);
                end else begin
                    d = q.pop_front();
                    ref_norm(d, rd, rs, rz);
                    chk("sweep_data", out_data, rd);
                    chk("sweep_shift", out_shift, rs);
                    chk("sweep_zero", out_zero, rz);
                end
                got++;
            end
            cyc++;
        end
        chk("sweep_count", got, 1000);
        chk("sweep_queue_empty", q.size(), 0);

        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
